// File: rtl/requant_sched_if.sv
// rtl/requant_sched_if.sv - stream bundle for requant_sched: per-channel input requests and tagged output words
interface requant_sched_if #(
    parameter int N_CH       = 4,
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 8
);
    localparam int CHW = $clog2(N_CH);

    logic [N_CH*DIN_WIDTH-1:0] din;
    logic [N_CH-1:0]           din_valid;
    logic [N_CH-1:0]           din_ready;
    logic [DOUT_WIDTH-1:0]     dout;
    logic [CHW-1:0]            dout_ch;
    logic [1:0]                dout_warning;
    logic                      dout_valid;
    logic                      dout_ready;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_ch, dout_warning, dout_valid
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_ch, dout_warning, dout_valid
    );
endinterface

// File: rtl/requant_sched.sv
// rtl/requant_sched.sv - round-robin shared fixed-point requantizer with 2-entry output buffer and saturation counters
module requant_sched #(
    parameter int N_CH       = 4,
    parameter int DIN_WIDTH  = 16,
    parameter int DIN_POINT  = 8,
    parameter int DOUT_WIDTH = 8,
    parameter int DOUT_POINT = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    requant_sched_if.slave       bus,
    input  logic [$clog2(N_CH)-1:0] sat_sel,
    input  logic                 sat_clr,
    output logic [CNT_WIDTH-1:0] sat_ovf_cnt,
    output logic [CNT_WIDTH-1:0] sat_unf_cnt
);
    localparam int CHW = $clog2(N_CH);
    localparam int SH  = DIN_POINT - DOUT_POINT;

    // Representable output range, sign-extended to the input width
    localparam logic signed [DIN_WIDTH-1:0] MAXV =
        {{(DIN_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [DIN_WIDTH-1:0] MINV =
        {{(DIN_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [DOUT_WIDTH-1:0] data;
        logic [CHW-1:0]        ch;
        logic [1:0]            warn;
    } entry_t;

    logic [CHW-1:0]        ptr;
    logic                  busy;
    entry_t                cast_q;
    entry_t                fifo [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic [CNT_WIDTH-1:0]  ovf_cnt [N_CH];
    logic [CNT_WIDTH-1:0]  unf_cnt [N_CH];

    logic                  pop;
    logic [2:0]            load;
    logic                  gnt_any;
    logic [CHW-1:0]        gnt_idx;
    logic [CHW-1:0]        idx;
    logic [DIN_WIDTH-1:0]  win_word;
    logic signed [DIN_WIDTH-1:0] shifted;
    logic [DOUT_WIDTH-1:0] cast_data;
    logic [1:0]            cast_warn;

    assign pop  = (count != 2'd0) && bus.dout_ready;
    // A word leaving the buffer this edge frees its slot for a new grant
    assign load = 3'(count) + 3'(busy) - 3'(pop);

    always_comb begin
        gnt_any       = 1'b0;
        gnt_idx       = '0;
        idx           = '0;
        bus.din_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = CHW'((int'(ptr) + i) % N_CH);
            if (!gnt_any && bus.din_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        if (rst || load >= 3'd2) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            bus.din_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        win_word  = bus.din[gnt_idx*DIN_WIDTH +: DIN_WIDTH];
        shifted   = $signed(win_word) >>> SH;
        cast_data = shifted[DOUT_WIDTH-1:0];
        cast_warn = 2'd0;
        if (shifted > MAXV) begin
            cast_data = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            cast_warn = 2'd1;
        end else if (shifted < MINV) begin
            cast_data = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            cast_warn = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            busy    <= 1'b0;
            cast_q  <= '0;
            fifo[0] <= '0;
            fifo[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            for (int c = 0; c < N_CH; c++) begin
                ovf_cnt[c] <= '0;
                unf_cnt[c] <= '0;
            end
        end else begin
            busy <= gnt_any;
            if (gnt_any) begin
                cast_q <= '{data: cast_data, ch: gnt_idx, warn: cast_warn};
                ptr    <= (gnt_idx == CHW'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
            end
            if (busy) begin
                fifo[wr_ptr] <= cast_q;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, busy} - {1'b0, pop};
            // Clear beats a coincident increment on the selected channel
            for (int c = 0; c < N_CH; c++) begin
                if (sat_clr && sat_sel == CHW'(c)) begin
                    ovf_cnt[c] <= '0;
                    unf_cnt[c] <= '0;
                end else if (gnt_any && gnt_idx == CHW'(c)) begin
                    if (cast_warn == 2'd1 && ovf_cnt[c] != '1) begin
                        ovf_cnt[c] <= ovf_cnt[c] + 1'b1;
                    end
                    if (cast_warn == 2'd2 && unf_cnt[c] != '1) begin
                        unf_cnt[c] <= unf_cnt[c] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.dout         = fifo[rd_ptr].data;
    assign bus.dout_ch      = fifo[rd_ptr].ch;
    assign bus.dout_warning = fifo[rd_ptr].warn;
    assign bus.dout_valid   = (count != 2'd0);
    assign sat_ovf_cnt      = ovf_cnt[sat_sel];
    assign sat_unf_cnt      = unf_cnt[sat_sel];
endmodule
